// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, oversampling constants and baud defaults for the UART tops
package uart_pkg;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STOP    = 3'd3;
    localparam logic [2:0] ST_WAIT_HI = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        START   = ST_START,
        DATA    = ST_DATA,
        STOP    = ST_STOP,
        WAIT_HI = ST_WAIT_HI
    } state_t;

    localparam int MID_TICK   = 7;
    localparam int OVERSAMPLE = 16;
    localparam int DEF_DIV    = 163;
    localparam int DEF_SIZ    = 8;
endpackage

// File: rtl/baud_gen.sv
// baud_gen: free-running modulo-M divider emitting a one-clock tick at count M-1
module baud_gen
    import uart_pkg::*;
#(
    parameter int N = DEF_SIZ,
    parameter int M = DEF_DIV
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic max_tick
);
    logic [N-1:0] q;

    assign max_tick = (q == N'(M - 1));

    // count 0..M-1 and wrap on the tick
    always_ff @(posedge i_clock)
        q <= (i_reset || max_tick) ? '0 : q + 1'b1;
endmodule

// File: rtl/uart_rx_full.sv
// uart_rx_full: 16x oversampled UART receiver with input synchronizer and framing-error flag
module uart_rx_full
    import uart_pkg::*;
#(
    parameter int DBIT    = 16,
    parameter int SB_TICK = 16,
    parameter int DIV     = DEF_DIV,
    parameter int SIZ     = DEF_SIZ
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            rx,
    output logic [DBIT-1:0] o_Data,
    output logic            rx_done,
    output logic            o_frame_err
);
    localparam int SW = $clog2(SB_TICK > OVERSAMPLE ? SB_TICK : OVERSAMPLE);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    state_t          state, state_n;
    logic [SW-1:0]   s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n, data_n;
    logic            done_n, ferr_n;
    logic [1:0]      sync;
    logic            rx_s, s_tick;

    baud_gen #(.N(SIZ), .M(DIV)) u_baud (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .max_tick (s_tick)
    );

    assign rx_s = sync[1];

    // two-flop synchronizer on the asynchronous line, reset to idle-high
    always_ff @(posedge i_clock)
        sync <= i_reset ? 2'b11 : {sync[0], rx};

    // FSM and datapath registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            b           <= '0;
            o_Data      <= '0;
            rx_done     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_n;
            s           <= s_n;
            n           <= n_n;
            b           <= b_n;
            o_Data      <= data_n;
            rx_done     <= done_n;
            o_frame_err <= ferr_n;
        end
    end

    // next-state: start edge checked every clock, everything else advances on ticks
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        data_n  = o_Data;
        done_n  = 1'b0;
        ferr_n  = o_frame_err;
        case (state)
            IDLE:
                if (!rx_s) begin
                    s_n     = '0;
                    state_n = START;
                end
            START:
                if (s_tick) begin
                    if (s == S_MID) begin
                        s_n     = '0;
                        n_n     = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else
                        s_n = s + 1'b1;
                end
            DATA:
                if (s_tick) begin
                    if (s == S_LAST) begin
                        b_n     = {rx_s, b[DBIT-1:1]};
                        s_n     = '0;
                        n_n     = (n == N_LAST) ? n : n + 1'b1;
                        state_n = (n == N_LAST) ? STOP : DATA;
                    end else
                        s_n = s + 1'b1;
                end
            STOP:
                if (s_tick) begin
                    if (s == S_STOP) begin
                        data_n  = b;
                        done_n  = 1'b1;
                        ferr_n  = ~rx_s;
                        state_n = rx_s ? IDLE : WAIT_HI;
                    end else
                        s_n = s + 1'b1;
                end
            WAIT_HI:
                if (rx_s) state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
    end
endmodule
